bm_infer_sched: RTL and testbench

// - Autonomous inference scheduler and pin-bus arbiter for the Bayesian stochastic/log chip.
// - Accepts 4-observation jobs over valid/ready and runs the chip through seed, address, inference and readout.
// - Returns one 32-bit result word (4 x 8-bit class outputs) per job.
// - Arbitrates the chip pin bus round-robin between its own sequencer and the host (AXI register/memory) controller.

---
 rtl/bm_infer_sched.sv | 265 ++++++++++++++++++++++++++
 tb/tb_bm_infer_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bm_infer_sched.sv
// Inference scheduler for the Bayesian stochastic/log chip: runs seed/address/inference/readout
// per 4-observation job and round-robin arbitrates the chip pin bus against the host controller.
module bm_infer_sched #(
  parameter int OBS_W     = 9,
  parameter int CYC_W     = 16,
  parameter int PULSE_CYC = 2,
  parameter int DUMMY_CYC = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CYC_W-1:0]   cfg_cycles,
  input  logic [7:0]         cfg_seed,
  input  logic               cfg_log,
  input  logic               obs_valid,
  output logic               obs_ready,
  input  logic [4*OBS_W-1:0] obs_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  input  logic               host_req,
  output logic               host_gnt,
  input  logic [34:0]        host_pins,
  output logic [34:0]        chip_pins,
  input  logic [3:0]         bit_out,
  output logic [15:0]        jobs_done
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_SEED = 4'd1,
    ST_SETUP     = 4'd2,
    ST_PRE       = 4'd3,
    ST_PULSE     = 4'd4,
    ST_OFF       = 4'd5,
    ST_RUN       = 4'd6,
    ST_READOUT   = 4'd7,
    ST_CLEAR     = 4'd8,
    ST_RESULT    = 4'd9
  } state_t;

  typedef enum logic {
    RR_HOST  = 1'b0,
    RR_SCHED = 1'b1
  } rr_t;

  typedef struct packed {
    logic       cbl;
    logic       cblen;
    logic       csl;
    logic       cwl;
    logic       inference;
    logic       load_seed;
    logic       read_1;
    logic       read_8;
    logic       load_mem;
    logic       read_out;
    logic       stoch_log;
    logic [7:0] col;
    logic [7:0] row;
    logic [7:0] seeds;
  } pins_t;

  localparam logic [CYC_W-1:0] PULSE_LAST = CYC_W'(PULSE_CYC - 1);
  localparam logic [CYC_W-1:0] DUMMY_LIM  = CYC_W'(DUMMY_CYC);
  localparam logic [CYC_W-1:0] READ_LAST  = CYC_W'(DUMMY_CYC + 7);

  state_t             state_q, state_d;
  rr_t                rr_last_q, rr_last_d;
  logic [1:0]         obs_idx_q, obs_idx_d;
  logic [CYC_W-1:0]   cnt_q, cnt_d;
  logic [CYC_W-1:0]   cyc_lat_q, cyc_lat_d;
  logic [4*OBS_W-1:0] obs_lat_q, obs_lat_d;
  logic [31:0]        res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;
  logic               idle_free_q, idle_free_d;
  logic               host_gnt_q, host_gnt_d;
  logic [15:0]        jobs_done_q, jobs_done_d;
  pins_t              sched_pins_q, sched_pins_d;
  logic [OBS_W-1:0]   obs_cur;
  logic               log_on;

  // The host loses an IDLE tie only when it was the last one granted.
  assign obs_ready = idle_free_q & ~(host_req & (rr_last_q == RR_SCHED));
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign host_gnt  = host_gnt_q;
  assign jobs_done = jobs_done_q;
  assign chip_pins = host_gnt_q ? host_pins : sched_pins_q;

  // Job sequencing, arbitration and result capture.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    obs_idx_d   = obs_idx_q;
    cnt_d       = cnt_q;
    cyc_lat_d   = cyc_lat_q;
    obs_lat_d   = obs_lat_q;
    res_data_d  = res_data_q;
    host_gnt_d  = host_gnt_q;
    jobs_done_d = jobs_done_q;

    case (state_q)
      ST_IDLE: begin
        if (host_gnt_q) begin
          host_gnt_d = host_req;
        end else if (idle_free_q) begin
          if (host_req && ((rr_last_q == RR_SCHED) || !obs_valid)) begin
            host_gnt_d = 1'b1;
            rr_last_d  = RR_HOST;
          end else if (obs_valid) begin
            state_d    = ST_LOAD_SEED;
            obs_lat_d  = obs_data;
            cyc_lat_d  = (cfg_cycles == {CYC_W{1'b0}}) ? CYC_W'(1) : cfg_cycles;
            res_data_d = 32'd0;
            obs_idx_d  = 2'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_SEED: begin
        state_d   = ST_SETUP;
        obs_idx_d = 2'd0;
      end
      ST_SETUP: state_d = ST_PRE;
      ST_PRE: begin
        state_d = ST_PULSE;
        cnt_d   = {CYC_W{1'b0}};
      end
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q + CYC_W'(1);
        end
      end
      ST_OFF: begin
        if (obs_idx_q == 2'd3) begin
          state_d = ST_RUN;
          cnt_d   = {CYC_W{1'b0}};
        end else begin
          state_d   = ST_SETUP;
          obs_idx_d = obs_idx_q + 2'd1;
        end
      end
      ST_RUN: begin
        if (cnt_q == (cyc_lat_q - CYC_W'(1))) begin
          state_d = ST_READOUT;
          cnt_d   = {CYC_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CYC_W'(1);
        end
      end
      ST_READOUT: begin
        if (cnt_q >= DUMMY_LIM) begin
          for (int j = 0; j < 4; j++) begin
            res_data_d[8*j +: 8] = {res_data_q[8*j +: 7], bit_out[j]};
          end
        end else begin
          res_data_d = res_data_q;
        end
        if (cnt_q == READ_LAST) begin
          state_d = ST_CLEAR;
        end else begin
          cnt_d = cnt_q + CYC_W'(1);
        end
      end
      ST_CLEAR: state_d = ST_RESULT;
      ST_RESULT: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          rr_last_d   = RR_SCHED;
          jobs_done_d = jobs_done_q + 16'd1;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    idle_free_d = (state_d == ST_IDLE) && !host_gnt_d;
    res_valid_d = (state_d == ST_RESULT);
  end

  // Pin levels are decoded from the next state so they line up with the state they belong to.
  always_comb begin
    sched_pins_d = '0;
    case (obs_idx_d)
      2'd0:    obs_cur = obs_lat_q[0*OBS_W +: OBS_W];
      2'd1:    obs_cur = obs_lat_q[1*OBS_W +: OBS_W];
      2'd2:    obs_cur = obs_lat_q[2*OBS_W +: OBS_W];
      2'd3:    obs_cur = obs_lat_q[3*OBS_W +: OBS_W];
      default: obs_cur = {OBS_W{1'b0}};
    endcase

    case (state_d)
      ST_SETUP, ST_PRE, ST_PULSE, ST_OFF, ST_RUN, ST_READOUT:
        log_on = (state_d != ST_SETUP) || (obs_idx_d != 2'd0);
      default:
        log_on = 1'b0;
    endcase

    case (state_d)
      ST_LOAD_SEED: begin
        sched_pins_d.load_seed = 1'b1;
        sched_pins_d.seeds     = cfg_seed;
      end
      ST_SETUP, ST_PRE, ST_PULSE, ST_OFF: begin
        sched_pins_d.col       = {obs_idx_d, 3'b000, obs_cur[2:0]};
        sched_pins_d.row       = 8'(obs_cur[OBS_W-1:3]);
        sched_pins_d.csl       = (state_d == ST_PRE);
        sched_pins_d.cwl       = (state_d == ST_PRE) || (state_d == ST_PULSE);
        sched_pins_d.read_8    = (state_d != ST_SETUP);
        sched_pins_d.inference = (state_d == ST_OFF);
      end
      ST_RUN, ST_READOUT: begin
        sched_pins_d.inference = 1'b1;
        sched_pins_d.read_8    = 1'b1;
        sched_pins_d.read_out  = (state_d == ST_READOUT);
      end
      ST_CLEAR: begin
        sched_pins_d.load_mem  = 1'b1;
        sched_pins_d.read_out  = 1'b1;
        sched_pins_d.inference = 1'b1;
      end
      default: sched_pins_d = '0;
    endcase

    sched_pins_d.stoch_log = cfg_log & log_on;
  end

  // State and output registers; rst abandons any running job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= RR_HOST;
      obs_idx_q    <= 2'd0;
      cnt_q        <= {CYC_W{1'b0}};
      cyc_lat_q    <= CYC_W'(1);
      obs_lat_q    <= {(4*OBS_W){1'b0}};
      res_data_q   <= 32'd0;
      res_valid_q  <= 1'b0;
      idle_free_q  <= 1'b0;
      host_gnt_q   <= 1'b0;
      jobs_done_q  <= 16'd0;
      sched_pins_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      obs_idx_q    <= obs_idx_d;
      cnt_q        <= cnt_d;
      cyc_lat_q    <= cyc_lat_d;
      obs_lat_q    <= obs_lat_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      idle_free_q  <= idle_free_d;
      host_gnt_q   <= host_gnt_d;
      jobs_done_q  <= jobs_done_d;
      sched_pins_q <= sched_pins_d;
    end
  end

endmodule

// File: tb/tb_bm_infer_sched.sv
// Directed bench for bm_infer_sched: job timing, pin sequencing, backpressure, reset abort
// and host/scheduler round-robin on the pin bus.
module tb_bm_infer_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_cycles;
  logic [7:0]  cfg_seed;
  logic        cfg_log;
  logic        obs_valid;
  logic        obs_ready;
  logic [35:0] obs_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        host_req;
  logic        host_gnt;
  logic [34:0] host_pins;
  logic [34:0] chip_pins;
  logic [3:0]  bit_out;
  logic [15:0] jobs_done;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat;
  int          bad;
  int          w;
  logic        seen;
  logic [34:0] hist [0:255];
  logic [31:0] rd_at1;

  localparam logic [35:0] OBS_A = {9'h000, 9'h1FF, 9'h10A, 9'h00F};
  localparam logic [35:0] OBS_B = {9'h0C3, 9'h055, 9'h1AA, 9'h007};

  bm_infer_sched dut (
    .clk(clk), .rst(rst), .cfg_cycles(cfg_cycles), .cfg_seed(cfg_seed), .cfg_log(cfg_log),
    .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_data(obs_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .host_req(host_req), .host_gnt(host_gnt), .host_pins(host_pins), .chip_pins(chip_pins),
    .bit_out(bit_out), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offers one job, then records chip_pins per cycle after the accept until res_valid.
  task automatic run_job(input logic [35:0] obs_word, input logic [15:0] cyc, output int n);
    int k;
    obs_data   = obs_word;
    cfg_cycles = cyc;
    obs_valid  = 1'b1;
    #1;
    k = 0;
    while (!obs_ready && k < 20) begin
      tick();
      k++;
    end
    check_eq("accept", 64'(obs_ready), 64'd1);
    tick();
    obs_valid  = 1'b0;
    obs_data   = '1;
    cfg_cycles = 16'hFFFF;
    n = 1;
    hist[1] = chip_pins;
    rd_at1  = res_data;
    while (!res_valid && n < 200) begin
      tick();
      n++;
      hist[n] = chip_pins;
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_cycles = 16'd0;
    cfg_seed   = 8'hA5;
    cfg_log    = 1'b1;
    obs_valid  = 1'b0;
    obs_data   = 36'd0;
    res_ready  = 1'b1;
    host_req   = 1'b0;
    host_pins  = 35'h5_A5A5_A5A5;
    bit_out    = 4'b0101;
    repeat (3) tick();
    check_eq("rst_obs_ready", 64'(obs_ready), 64'd0);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_res_data", 64'(res_data), 64'd0);
    check_eq("rst_host_gnt", 64'(host_gnt), 64'd0);
    check_eq("rst_jobs_done", 64'(jobs_done), 64'd0);
    check_eq("rst_chip_pins", 64'(chip_pins), 64'd0);
    rst = 1'b0;
    tick();
    tick();

    // Job 1: cfg_cycles=10, log mode, bit_out 0101.
    run_job(OBS_A, 16'd10, lat);
    check_eq("j1_latency", 64'(lat), 64'd44);
    check_eq("j1_res_data", 64'(res_data), 64'h00FF00FF);
    check_eq("j1_load_seed", 64'(hist[1]), 64'h0200000A5);
    check_eq("j1_setup0", 64'(hist[2]), 64'h000070100);
    check_eq("j1_setup1", 64'(hist[7]), 64'h001422100);
    check_eq("j1_pre1", 64'(hist[8]), 64'h189422100);
    check_eq("j1_pulse1a", 64'(hist[9]), 64'h089422100);
    check_eq("j1_pulse1b", 64'(hist[10]), 64'h089422100);
    check_eq("j1_off1", 64'(hist[11]), 64'h049422100);
    check_eq("j1_run", 64'(hist[22]), 64'h049000000);
    check_eq("j1_readout", 64'(hist[32]), 64'h04B000000);
    check_eq("j1_clear", 64'(hist[43]), 64'h046000000);
    check_eq("j1_result_pins", 64'(hist[44]), 64'd0);
    check_eq("j1_ready_busy", 64'(obs_ready), 64'd0);
    tick();
    check_eq("j1_jobs_done", 64'(jobs_done), 64'd1);
    check_eq("j1_valid_drop", 64'(res_valid), 64'd0);
    check_eq("j1_res_hold", 64'(res_data), 64'h00FF00FF);

    // Job 2: cfg_cycles=0 runs one inference cycle.
    cfg_log = 1'b0;
    bit_out = 4'b1010;
    run_job(OBS_B, 16'd0, lat);
    check_eq("j2_latency", 64'(lat), 64'd35);
    check_eq("j2_res_cleared", 64'(rd_at1), 64'd0);
    check_eq("j2_res_data", 64'(res_data), 64'hFF00FF00);
    check_eq("j2_run", 64'(hist[22]), 64'h048000000);
    check_eq("j2_readout", 64'(hist[23]), 64'h04A000000);
    tick();
    check_eq("j2_jobs_done", 64'(jobs_done), 64'd2);

    // Job 3: result held under backpressure for 20 cycles.
    res_ready = 1'b0;
    bit_out   = 4'b0011;
    run_job(OBS_A, 16'd3, lat);
    check_eq("j3_latency", 64'(lat), 64'd37);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!res_valid || res_data !== 32'h0000FFFF || obs_ready || jobs_done !== 16'd2) bad++;
    end
    check_eq("j3_hold_bad_cycles", 64'(bad), 64'd0);
    check_eq("j3_res_data", 64'(res_data), 64'h0000FFFF);
    res_ready = 1'b1;
    tick();
    check_eq("j3_jobs_done", 64'(jobs_done), 64'd3);
    check_eq("j3_valid_drop", 64'(res_valid), 64'd0);

    // Reset pulsed during RUN aborts the job.
    obs_data   = OBS_B;
    cfg_cycles = 16'd10;
    obs_valid  = 1'b1;
    #1;
    w = 0;
    while (!obs_ready && w < 20) begin
      tick();
      w++;
    end
    check_eq("abort_accept", 64'(obs_ready), 64'd1);
    tick();
    obs_valid = 1'b0;
    repeat (24) tick();
    check_eq("abort_in_run", 64'(chip_pins), 64'h048000000);
    rst = 1'b1;
    tick();
    check_eq("abort_chip_pins", 64'(chip_pins), 64'd0);
    check_eq("abort_res_valid", 64'(res_valid), 64'd0);
    check_eq("abort_jobs_done", 64'(jobs_done), 64'd0);
    check_eq("abort_res_data", 64'(res_data), 64'd0);
    rst = 1'b0;

    // Host and job request together after reset: the job goes first.
    host_req = 1'b1;
    bit_out  = 4'b1111;
    run_job(OBS_A, 16'd2, lat);
    check_eq("rr_latency", 64'(lat), 64'd36);
    check_eq("rr_sched_bus", 64'(hist[1]), 64'h0200000A5);
    check_eq("rr_no_gnt_in_job", 64'(host_gnt), 64'd0);
    check_eq("rr_res_data", 64'(res_data), 64'hFFFFFFFF);
    obs_data   = OBS_B;
    cfg_cycles = 16'd5;
    obs_valid  = 1'b1;
    w    = 0;
    seen = 1'b0;
    while (!host_gnt && w < 6) begin
      tick();
      w++;
      if (obs_ready) seen = 1'b1;
    end
    check_eq("rr_host_gnt", 64'(host_gnt), 64'd1);
    check_eq("rr_obs_blocked", 64'(seen), 64'd0);
    check_eq("rr_jobs_done", 64'(jobs_done), 64'd1);
    check_eq("rr_bus_host", 64'(chip_pins), 64'h5A5A5A5A5);
    host_pins = 35'h2_3456_789A;
    #1;
    check_eq("rr_bus_host_live", 64'(chip_pins), 64'h23456789A);
    tick();
    check_eq("rr_gnt_held", 64'(host_gnt), 64'd1);
    check_eq("rr_ready_while_gnt", 64'(obs_ready), 64'd0);
    host_req = 1'b0;
    tick();
    check_eq("rr_gnt_release", 64'(host_gnt), 64'd0);
    check_eq("rr_bus_idle", 64'(chip_pins), 64'd0);

    // The waiting job now runs normally.
    bit_out = 4'b1001;
    run_job(OBS_B, 16'd5, lat);
    check_eq("j5_latency", 64'(lat), 64'd39);
    check_eq("j5_res_data", 64'(res_data), 64'hFF0000FF);
    tick();
    check_eq("j5_jobs_done", 64'(jobs_done), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
